sync_fifo: RTL and testbench

- Parametrised single-clock circular-buffer FIFO; successor to the fixed 4x32 shift-register FIFO.
- True first-in-first-out ordering with separate read/write pointers and an occupancy counter.
- Supports simultaneous push/pop, exact full/empty flags, and sticky overflow/underflow error flags.
- Sits between producer/consumer blocks in the datapath as the standard buffering element.

---
 rtl/sync_fifo.sv | 132 +++++++++++++
 tb/tb_sync_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular-buffer FIFO with sticky overflow/underflow flags
// Optional registered almost_full/almost_empty outputs are enabled with SYNC_FIFO_ALMOST_EN.
module sync_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             dataIn,
  output logic [WIDTH-1:0]             fifo_out,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow,
  output logic                         underflow,
`ifdef SYNC_FIFO_ALMOST_EN
  output logic                         almost_full,
  output logic                         almost_empty,
`endif
  input  logic                         clear_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_fifo_out;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CW-1:0]    w_next_count;

  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + PW'(1);
  endfunction

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_pop_ok   = pop & ~w_empty;
  // A pop accepted in the same cycle frees the slot, so a full FIFO can still take a push.
  assign w_push_ok  = push & (~w_full | w_pop_ok);

  always_comb begin
    w_next_count = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_next_count = r_count + CW'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_next_count = r_count - CW'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_fifo_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count <= w_next_count;
      if (w_push_ok) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= f_next_ptr(r_rd_ptr);
        r_fifo_out <= r_mem[r_rd_ptr];
      end
      // A new error event takes priority over clear_err in the same cycle.
      if (push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end else if (clear_err) begin
        r_overflow <= 1'b0;
      end
      if (pop && !w_pop_ok) begin
        r_underflow <= 1'b1;
      end else if (clear_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign fifo_out   = r_fifo_out;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

`ifdef SYNC_FIFO_ALMOST_EN
  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b0;
    end else begin
      r_almost_full  <= (int'(w_next_count) >= AF_LEVEL);
      r_almost_empty <= (int'(w_next_count) <= AE_LEVEL);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`else
  // Threshold levels have no effect in this build; this block only keeps them referenced.
  if (AF_LEVEL < 0 || AE_LEVEL < 0) begin : g_levels_unused
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo, DEPTH=4 and DEPTH=3 instances on shared stimulus
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic        clear_err;
  logic [31:0] din;

  logic [31:0] out4, out3;
  logic        full4, full3, empty4, empty3, ovf4, ovf3, udf4, udf3;
  logic [2:0]  cnt4;
  logic [1:0]  cnt3;
`ifdef SYNC_FIFO_ALMOST_EN
  logic        af4, af3, ae4, ae3;
`endif

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(32), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .dataIn(din),
    .fifo_out(out4), .fifo_full(full4), .fifo_empty(empty4), .fifo_count(cnt4),
    .overflow(ovf4), .underflow(udf4),
`ifdef SYNC_FIFO_ALMOST_EN
    .almost_full(af4), .almost_empty(ae4),
`endif
    .clear_err(clear_err)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .dataIn(din),
    .fifo_out(out3), .fifo_full(full3), .fifo_empty(empty3), .fifo_count(cnt3),
    .overflow(ovf3), .underflow(udf3),
`ifdef SYNC_FIFO_ALMOST_EN
    .almost_full(af3), .almost_empty(ae3),
`endif
    .clear_err(clear_err)
  );

  typedef struct {
    int          due;
    int          inst;
    logic [31:0] out;
    int          cnt;
    bit          ovf;
    bit          udf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq [2][$];
  int          depth [2] = '{4, 3};
  logic [31:0] m_out [2];
  bit          m_ovf [2];
  bit          m_udf [2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_out[i] = '0;
      m_ovf[i] = 1'b0;
      m_udf[i] = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus and record what each instance must show after the edge.
  task automatic step(input bit p, input bit q, input logic [31:0] d, input bit c);
    exp_t e;
    @(posedge clk);
    #1;
    push = p; pop = q; din = d; clear_err = c;
    for (int i = 0; i < 2; i++) begin
      bit pop_ok, push_ok;
      pop_ok  = q && (mq[i].size() > 0);
      push_ok = p && ((mq[i].size() < depth[i]) || pop_ok);
      if (pop_ok)  m_out[i] = mq[i].pop_front();
      if (push_ok) mq[i].push_back(d);
      if (p && !push_ok) m_ovf[i] = 1'b1;
      else if (c)        m_ovf[i] = 1'b0;
      if (q && !pop_ok)  m_udf[i] = 1'b1;
      else if (c)        m_udf[i] = 1'b0;
      e.due = cyc + 1; e.inst = i; e.out = m_out[i]; e.cnt = mq[i].size();
      e.ovf = m_ovf[i]; e.udf = m_udf[i];
      sb.push_back(e);
    end
  endtask

  task automatic check_inst(input exp_t e);
    string       tag;
    logic [31:0] a_out;
    int          a_cnt, dep;
    bit          a_full, a_empty, a_ovf, a_udf;
    tag     = (e.inst == 0) ? "d4" : "d3";
    dep     = (e.inst == 0) ? 4 : 3;
    a_out   = (e.inst == 0) ? out4 : out3;
    a_cnt   = (e.inst == 0) ? int'(cnt4) : int'(cnt3);
    a_full  = (e.inst == 0) ? full4 : full3;
    a_empty = (e.inst == 0) ? empty4 : empty3;
    a_ovf   = (e.inst == 0) ? ovf4 : ovf3;
    a_udf   = (e.inst == 0) ? udf4 : udf3;
    chk({tag, ".fifo_out"},   a_out, e.out);
    chk({tag, ".fifo_count"}, 32'(a_cnt), 32'(e.cnt));
    chk({tag, ".fifo_full"},  32'(a_full), 32'(e.cnt == dep));
    chk({tag, ".fifo_empty"}, 32'(a_empty), 32'(e.cnt == 0));
    chk({tag, ".overflow"},   32'(a_ovf), 32'(e.ovf));
    chk({tag, ".underflow"},  32'(a_udf), 32'(e.udf));
`ifdef SYNC_FIFO_ALMOST_EN
    chk({tag, ".almost_full"},  32'((e.inst == 0) ? af4 : af3), 32'(e.cnt >= dep - 1));
    chk({tag, ".almost_empty"}, 32'((e.inst == 0) ? ae4 : ae3), 32'(e.cnt <= 1));
`endif
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stale_entry inst %0d: due %0d but now %0d", e.inst, e.due, cyc);
      end else begin
        check_inst(e);
      end
    end
  end

  task automatic check_reset_state(input string nm);
    chk({nm, ".d4.count"}, 32'(cnt4), 0);
    chk({nm, ".d4.empty"}, 32'(empty4), 1);
    chk({nm, ".d4.full"},  32'(full4), 0);
    chk({nm, ".d4.out"},   out4, 0);
    chk({nm, ".d4.ovf"},   32'(ovf4), 0);
    chk({nm, ".d4.udf"},   32'(udf4), 0);
    chk({nm, ".d3.count"}, 32'(cnt3), 0);
    chk({nm, ".d3.empty"}, 32'(empty3), 1);
    chk({nm, ".d3.out"},   out3, 0);
`ifdef SYNC_FIFO_ALMOST_EN
    chk({nm, ".d4.af"}, 32'(af4), 0);
    chk({nm, ".d4.ae"}, 32'(ae4), 0);
`endif
  endtask

  task automatic push_n(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) step(1, 0, base + 32'(k), 0);
  endtask

  task automatic pop_n(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 32'hDEAD_0000 + 32'(k), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; push = 0; pop = 0; clear_err = 0; din = '0;
    model_reset();
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Fill and drain in order
    push_n(32'hA0, 4);
    pop_n(4);
    // Overflow on a full FIFO, then drain and clear the sticky flag
    push_n(32'hA0, 4);
    step(1, 0, 32'hFF, 0);
    pop_n(4);
    step(0, 0, 0, 1);
    // Simultaneous push/pop while full returns the old head
    push_n(32'hA0, 4);
    step(1, 1, 32'hB0, 0);
    pop_n(4);
    // Simultaneous push/pop while empty: push wins, pop underflows
    step(1, 1, 32'hC0, 0);
    step(0, 1, 0, 0);
    // clear_err coinciding with a new underflow: set wins
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    // Interleaved stream 1..10 wraps the pointers on both depths
    step(1, 0, 1, 0);
    for (int k = 2; k <= 10; k++) step(1, 1, 32'(k), 0);
    step(0, 1, 0, 0);

    // Asynchronous reset between edges with three entries held
    push_n(32'h30, 3);
    step(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_state("async_reset");
    #1 reset = 1'b0;
    model_reset();

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom,
           $urandom_range(0, 15) == 0);
    end
    step(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
